// File: rtl/pio_od_port.sv
// Avalon-MM PIO for open-drain bit-banged buses: output latch, drive enable, set/clear, synchronised readback.
// Optional edge capture + maskable irq is built only when PIO_OD_PORT_EDGE_IRQ_EN is defined.
module pio_od_port #(
   parameter int unsigned      WIDTH       = 8,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   parameter int unsigned      SYNC_STAGES = 2,
   parameter int unsigned      EDGE_TYPE   = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [WIDTH-1:0] writedata,
   output logic [WIDTH-1:0] readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic [WIDTH-1:0] out_port,
   output logic [WIDTH-1:0] oe_port,
   output logic             irq
);

   localparam logic [2:0] ADDR_DATA    = 3'd0;
   localparam logic [2:0] ADDR_DIR     = 3'd1;
   localparam logic [2:0] ADDR_IRQMASK = 3'd2;
   localparam logic [2:0] ADDR_EDGECAP = 3'd3;
   localparam logic [2:0] ADDR_OUTSET  = 3'd4;
   localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

   logic             wr_en;
   logic [WIDTH-1:0] sync_pipe [SYNC_STAGES];
   logic [WIDTH-1:0] pin_sync;
   logic [WIDTH-1:0] irq_mask_q;
   logic [WIDTH-1:0] edge_cap_q;

   assign wr_en = chipselect & ~write_n;

   // Synchroniser resets to all ones so an idle-high bus never looks like it just fell.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_pipe[i] <= '1;
      end else begin
         sync_pipe[0] <= in_port;
         for (int i = 1; i < SYNC_STAGES; i++) sync_pipe[i] <= sync_pipe[i-1];
      end
   end

   assign pin_sync = sync_pipe[SYNC_STAGES-1];

   always_ff @(posedge clk) begin
      if (reset) begin
         out_port <= RESET_VALUE;
         oe_port  <= '0;
      end else if (wr_en) begin
         case (address)
            ADDR_DATA:   out_port <= writedata;
            ADDR_DIR:    oe_port  <= writedata;
            ADDR_OUTSET: out_port <= out_port | writedata;
            ADDR_OUTCLR: out_port <= out_port & ~writedata;
            default:     ;
         endcase
      end
   end

`ifdef PIO_OD_PORT_EDGE_IRQ_EN
   logic [WIDTH-1:0] hist_q;
   logic [WIDTH-1:0] edge_det;
   logic [WIDTH-1:0] cap_clr;

   function automatic logic [WIDTH-1:0] detect_edge(input logic [WIDTH-1:0] cur,
                                                    input logic [WIDTH-1:0] prev);
      if (EDGE_TYPE == 0)      return cur & ~prev;
      else if (EDGE_TYPE == 1) return ~cur & prev;
      else                     return cur ^ prev;
   endfunction

   assign edge_det = detect_edge(pin_sync, hist_q);
   assign cap_clr  = (wr_en && address == ADDR_EDGECAP) ? writedata : '0;

   // A new edge overrides a write-1-clear landing on the same bit in the same cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         hist_q     <= '1;
         irq_mask_q <= '0;
         edge_cap_q <= '0;
      end else begin
         hist_q     <= pin_sync;
         edge_cap_q <= (edge_cap_q & ~cap_clr) | edge_det;
         if (wr_en && address == ADDR_IRQMASK) irq_mask_q <= writedata;
      end
   end

   assign irq = |(edge_cap_q & irq_mask_q);
`else
   logic unused_edge_type;

   assign unused_edge_type = (EDGE_TYPE > 2);
   assign irq_mask_q       = '0;
   assign edge_cap_q       = '0;
   assign irq              = 1'b0;
`endif

   always_comb begin
      readdata = '0;
      case (address)
         ADDR_DATA:    readdata = pin_sync;
         ADDR_DIR:     readdata = oe_port;
         ADDR_IRQMASK: readdata = irq_mask_q;
         ADDR_EDGECAP: readdata = edge_cap_q;
         default:      readdata = '0;
      endcase
   end

endmodule

// File: tb/tb_pio_od_port.sv
// Directed bench for pio_od_port (WIDTH=8, RESET_VALUE=A5, SYNC_STAGES=2, EDGE_TYPE=falling).
// Edge/irq expectations follow whether PIO_OD_PORT_EDGE_IRQ_EN is defined for the build.
module tb_pio_od_port;

`ifdef PIO_OD_PORT_EDGE_IRQ_EN
   localparam bit EDGE_EN = 1'b1;
`else
   localparam bit EDGE_EN = 1'b0;
`endif

   logic       clk;
   logic       reset;
   logic [2:0] address;
   logic       chipselect;
   logic       write_n;
   logic [7:0] writedata;
   logic [7:0] readdata;
   logic [7:0] in_port;
   logic [7:0] out_port;
   logic [7:0] oe_port;
   logic       irq;

   int checks = 0;
   int errors = 0;

   pio_od_port #(
      .WIDTH       (8),
      .RESET_VALUE (8'hA5),
      .SYNC_STAGES (2),
      .EDGE_TYPE   (1)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .in_port    (in_port),
      .out_port   (out_port),
      .oe_port    (oe_port),
      .irq        (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   // All tasks start and end on a falling edge.
   task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic rd_check(input string tag, input logic [2:0] a, input logic [7:0] exp);
      address    = a;
      chipselect = 1'b1;
      write_n    = 1'b1;
      #1;
      check(tag, readdata, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      reset      = 1'b1;
      address    = 3'd0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = 8'h00;
      in_port    = 8'hFF;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      check("rst_out", out_port, 8'hA5);
      check("rst_oe", oe_port, 8'h00);
      check("rst_irq", irq, 1'b0);
      rd_check("rst_rd0", 3'd0, 8'hFF);
      rd_check("rst_rd1", 3'd1, 8'h00);
      rd_check("rst_rd2", 3'd2, 8'h00);
      rd_check("rst_rd3", 3'd3, 8'h00);
      @(negedge clk);
      rd_check("rst_rd4", 3'd4, 8'h00);
      rd_check("rst_rd5", 3'd5, 8'h00);
      rd_check("rst_rd6", 3'd6, 8'h00);
      rd_check("rst_rd7", 3'd7, 8'h00);
      @(negedge clk);

      bus_write(3'd1, 8'h0F);
      check("dir_oe", oe_port, 8'h0F);
      rd_check("dir_rd", 3'd1, 8'h0F);
      @(negedge clk);

      bus_write(3'd0, 8'h00);
      check("data_00", out_port, 8'h00);
      bus_write(3'd4, 8'h81);
      check("outset_81", out_port, 8'h81);
      bus_write(3'd5, 8'h01);
      check("outclr_80", out_port, 8'h80);
      rd_check("outset_rd", 3'd4, 8'h00);
      rd_check("outclr_rd", 3'd5, 8'h00);
      rd_check("data_rd_pin", 3'd0, 8'hFF);
      @(negedge clk);

      bus_write(3'd6, 8'hFF);
      check("rsvd6_out", out_port, 8'h80);
      check("rsvd6_oe", oe_port, 8'h0F);
      // Write strobe without chipselect must be ignored.
      address = 3'd0; writedata = 8'h5A; chipselect = 1'b0; write_n = 1'b0;
      @(negedge clk);
      write_n = 1'b1;
      check("nocs_out", out_port, 8'h80);

      bus_write(3'd2, 8'hFF);
      rd_check("mask_ff", 3'd2, EDGE_EN ? 8'hFF : 8'h00);
      @(negedge clk);
      bus_write(3'd2, 8'h08);
      rd_check("mask_08", 3'd2, EDGE_EN ? 8'h08 : 8'h00);
      check("mask_irq0", irq, 1'b0);
      @(negedge clk);

      // bit3 falls: readback after 2 edges, capture after 3.
      in_port = 8'hF7;
      @(negedge clk);
      rd_check("sync_e1", 3'd0, 8'hFF);
      @(negedge clk);
      rd_check("sync_e2", 3'd0, 8'hF7);
      rd_check("cap_e2", 3'd3, 8'h00);
      check("irq_e2", irq, 1'b0);
      @(negedge clk);
      rd_check("cap_e3", 3'd3, EDGE_EN ? 8'h08 : 8'h00);
      check("irq_e3", irq, EDGE_EN);
      @(negedge clk);

      bus_write(3'd3, 8'h08);
      rd_check("cap_clr", 3'd3, 8'h00);
      check("irq_clr", irq, 1'b0);
      @(negedge clk);

      bus_write(3'd2, 8'h01);
      // bit0 falls and is captured.
      in_port = 8'hF6;
      repeat (3) @(negedge clk);
      rd_check("cap_b0", 3'd3, EDGE_EN ? 8'h01 : 8'h00);
      check("irq_b0", irq, EDGE_EN);
      @(negedge clk);
      // Rising edge is not captured with falling-edge selection; clear first.
      bus_write(3'd3, 8'h01);
      in_port = 8'hF7;
      repeat (3) @(negedge clk);
      rd_check("cap_rise", 3'd3, 8'h00);
      check("irq_rise", irq, 1'b0);
      @(negedge clk);
      // Re-arm bit0, then collide its next falling edge with a clear.
      in_port = 8'hF6;
      repeat (3) @(negedge clk);
      bus_write(3'd3, 8'h01);
      in_port = 8'hF7;
      repeat (3) @(negedge clk);
      rd_check("cap_prearm", 3'd3, 8'h00);
      @(negedge clk);
      in_port = 8'hF6;
      @(negedge clk);
      @(negedge clk);
      bus_write(3'd3, 8'h01);
      rd_check("collide_cap", 3'd3, EDGE_EN ? 8'h01 : 8'h00);
      check("collide_irq", irq, EDGE_EN);
      @(negedge clk);

      bus_write(3'd2, 8'h00);
      check("mask_off_irq", irq, 1'b0);

      // Reset wins over a concurrent write.
      reset = 1'b1; address = 3'd0; writedata = 8'h3C; chipselect = 1'b1; write_n = 1'b0;
      @(negedge clk);
      chipselect = 1'b0; write_n = 1'b1;
      check("mid_rst_out", out_port, 8'hA5);
      check("mid_rst_oe", oe_port, 8'h00);
      check("mid_rst_irq", irq, 1'b0);
      rd_check("mid_rst_pin", 3'd0, 8'hFF);
      rd_check("mid_rst_cap", 3'd3, 8'h00);
      reset = 1'b0;
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
